// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: pipeline writeback (A) has priority,
// mul/div (B) is force-granted after MAX_WAIT refusals; tracks pending B destinations.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        b_issue,
    input  logic [4:0]  b_issue_addr,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    input  logic [4:0]  chk_addr3,
    output logic        chk_hit,
    output logic [31:0] busy_vec,
    output logic        wr_e,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      busy_q, busy_d;
    logic             force_b, grant_a, grant_b;
    logic [4:0]       mux_addr;
    logic [31:0]      mux_data;

    always_comb begin
        force_b  = b_valid && (wait_cnt_q >= MAX_CNT);
        grant_b  = b_valid && (!a_valid || force_b);
        grant_a  = a_valid && !force_b;
        mux_addr = '0;
        mux_data = '0;
        if (grant_a) begin
            mux_addr = a_addr;
            mux_data = a_data;
        end else if (grant_b) begin
            mux_addr = b_addr;
            mux_data = b_data;
        end
    end

    // Outputs are gated by rstb so they read zero for the whole reset window.
    assign a_ready  = rstb && !force_b;
    assign b_ready  = rstb && grant_b;
    assign wr_e     = rstb && (grant_a || grant_b) && (mux_addr != 5'd0);
    assign wr_addr  = rstb ? mux_addr : 5'd0;
    assign wr_data  = rstb ? mux_data : 32'd0;
    assign busy_vec = busy_q;
    assign chk_hit  = rstb && (busy_q[chk_addr1] || busy_q[chk_addr2] || busy_q[chk_addr3]);

    always_comb begin
        if (!b_valid || grant_b) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q >= MAX_CNT) begin
            wait_cnt_d = MAX_CNT;
        end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Issue is applied after the clear so a same-cycle reissue keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (grant_b) begin
            busy_d[b_addr] = 1'b0;
        end
        if (b_issue) begin
            busy_d[b_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wait_cnt_q <= '0;
            busy_q     <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model
// that tracks B's waiting time as an integer and pending registers as a bit array.
module tb_regfile_wb_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rstb;
    logic        a_valid, b_valid, b_issue;
    logic [4:0]  a_addr, b_addr, b_issue_addr, chk_addr1, chk_addr2, chk_addr3;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, chk_hit, wr_e;
    logic [31:0] busy_vec, wr_data;
    logic [4:0]  wr_addr;

    int checks = 0;
    int errors = 0;

    int  m_wait;
    bit  m_busy [32];
    bit  m_gb;
    bit  b_pend;

    regfile_wb_arbiter #(.MAX_WAIT(MW), .CNT_W(4)) dut (
        .clk(clk), .rstb(rstb),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .b_issue(b_issue), .b_issue_addr(b_issue_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_addr3(chk_addr3),
        .chk_hit(chk_hit), .busy_vec(busy_vec),
        .wr_e(wr_e), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic void model_reset();
        m_wait = 0;
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    endfunction

    // B is owed the port once it has been refused MW times in a row.
    task automatic check_all();
        bit          owed, ga, gb, we;
        logic [4:0]  ea;
        logic [31:0] ed;
        owed = b_valid && (m_wait >= MW);
        gb   = b_valid && (!a_valid || owed);
        ga   = a_valid && !owed;
        ea   = ga ? a_addr : (gb ? b_addr : 5'd0);
        ed   = ga ? a_data : (gb ? b_data : 32'd0);
        we   = (ga || gb) && (ea != 5'd0);
        if (!rstb) begin
            ga = 0; gb = 0; we = 0; ea = 0; ed = 0; owed = 1;
        end
        m_gb = gb;
        check("a_ready", 32'(a_ready), 32'(!owed));
        check("b_ready", 32'(b_ready), 32'(gb));
        check("wr_e", 32'(wr_e), 32'(we));
        check("wr_addr", 32'(wr_addr), 32'(ea));
        check("wr_data", wr_data, ed);
        check("busy_vec", busy_vec, model_busy());
        check("chk_hit", 32'(chk_hit),
              32'(rstb && (m_busy[chk_addr1] || m_busy[chk_addr2] || m_busy[chk_addr3])));
    endtask

    task automatic model_next();
        if (!rstb) begin
            model_reset();
            return;
        end
        if (!b_valid || m_gb) m_wait = 0;
        else if (m_wait < MW) m_wait++;
        for (int r = 1; r < 32; r++) begin
            if (b_issue && b_issue_addr == r) m_busy[r] = 1'b1;
            else if (m_gb && b_addr == r) m_busy[r] = 1'b0;
        end
    endtask

    // Inputs are driven right after a falling edge; outputs are sampled 1 ns later.
    task automatic step();
        check_all();
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                       input bit iss, input logic [4:0] ia);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        b_issue = iss; b_issue_addr = ia;
        #1;
    endtask

    initial begin
        bit exp_b [6];
        exp_b = '{0, 0, 0, 0, 1, 0};
        chk_addr1 = 0; chk_addr2 = 0; chk_addr3 = 0;
        model_reset();
        m_gb = 0;

        rstb = 1'b0;
        drv(1, 5'd4, 32'h1111_1111, 1, 5'd6, 32'h2222_2222, 1, 5'd8);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_wr_e", 32'(wr_e), 32'd0);
        check("rst_busy", busy_vec, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_busy_after_edge", busy_vec, 32'd0);
        rstb = 1'b1;
        model_reset();

        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_a_ready", 32'(a_ready), 32'd1);
        step();

        drv(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        check("a_only_wr_e", 32'(wr_e), 32'd1);
        check("a_only_wr_addr", 32'(wr_addr), 32'd5);
        check("a_only_wr_data", wr_data, 32'hDEAD_BEEF);
        check("a_only_b_ready", 32'(b_ready), 32'd0);
        step();

        for (int c = 0; c < 6; c++) begin
            drv(1, 5'(10 + c), 32'(c), 1, 5'd9, 32'h1234_5678, 0, 0);
            check($sformatf("contend_b_ready_c%0d", c + 1), 32'(b_ready), 32'(exp_b[c]));
            check($sformatf("contend_a_ready_c%0d", c + 1), 32'(a_ready), 32'(!exp_b[c]));
            if (exp_b[c]) begin
                check("forced_wr_addr", 32'(wr_addr), 32'd9);
                check("forced_wr_data", wr_data, 32'h1234_5678);
            end
            step();
        end

        drv(1, 5'd0, 32'hAAAA_AAAA, 0, 0, 0, 0, 0);
        check("zero_a_ready", 32'(a_ready), 32'd1);
        check("zero_a_wr_e", 32'(wr_e), 32'd0);
        step();
        drv(0, 0, 0, 1, 5'd0, 32'hBBBB_BBBB, 0, 0);
        check("zero_b_ready", 32'(b_ready), 32'd1);
        check("zero_b_wr_e", 32'(wr_e), 32'd0);
        step();

        chk_addr2 = 5'd7;
        drv(0, 0, 0, 0, 0, 0, 1, 5'd7);
        check("issue_not_visible_yet", 32'(chk_hit), 32'd0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("busy7_set", 32'(busy_vec[7]), 32'd1);
        check("chk_hit7", 32'(chk_hit), 32'd1);
        step();
        drv(0, 0, 0, 1, 5'd7, 32'h7777_7777, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("busy7_cleared", 32'(busy_vec[7]), 32'd0);
        step();
        drv(0, 0, 0, 0, 0, 0, 1, 5'd7);
        step();
        drv(0, 0, 0, 1, 5'd7, 32'h7, 1, 5'd7);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("busy7_reissue_kept", 32'(busy_vec[7]), 32'd1);
        step();
        drv(0, 0, 0, 1, 5'd7, 32'h7, 0, 0);
        step();

        drv(0, 0, 0, 0, 0, 0, 1, 5'd3);
        step();
        for (int c = 0; c < 3; c++) begin
            drv(1, 5'd1, 32'(c), 1, 5'd3, 32'h3333_3333, 0, 0);
            step();
        end
        drv(1, 5'd1, 32'h5, 1, 5'd3, 32'h3333_3333, 0, 0);
        check("pre_rst_busy3", 32'(busy_vec[3]), 32'd1);
        rstb = 1'b0;
        #1;
        model_reset();
        check("async_a_ready", 32'(a_ready), 32'd0);
        check("async_b_ready", 32'(b_ready), 32'd0);
        check("async_wr_e", 32'(wr_e), 32'd0);
        check("async_wr_data", wr_data, 32'd0);
        check("async_busy", busy_vec, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drv(1, 5'd2, 32'(c), 1, 5'd3, 32'h3333_3333, 0, 0);
            check($sformatf("post_rst_b_ready_c%0d", c + 1), 32'(b_ready), 32'(exp_b[c]));
            step();
        end

        b_pend = 0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            bit          av, bv, iss;
            logic [4:0]  aa, ba, ia;
            logic [31:0] ad, bd;
            av = ($urandom_range(0, 3) != 0);
            aa = 5'($urandom);
            ad = $urandom;
            if (b_pend) begin
                bv = 1; ba = b_addr; bd = b_data;
            end else begin
                bv = ($urandom_range(0, 2) == 0);
                ba = 5'($urandom);
                bd = $urandom;
            end
            iss = ($urandom_range(0, 3) == 0);
            ia  = 5'($urandom);
            chk_addr1 = 5'($urandom);
            chk_addr2 = 5'($urandom);
            chk_addr3 = 5'($urandom);
            drv(av, aa, ad, bv, ba, bd, iss, ia);
            step();
            b_pend = bv && !m_gb;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
